// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM with a shared instruction/data memory port and request timeout.
// Define MC_ILLEGAL_TRAP_EN to halt with err_o on unknown opcodes/funcs instead of retiring them as NOPs.
module mc_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned INSTR_NUM   = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  op_i,
  input  logic [5:0]  func_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] pc_i,
  input  logic        zero_i,
  input  logic        addr_ok_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_sel_o,
  output logic        mem_we_o,
  output logic        pc_we_o,
  output logic        pc_src_o,
  output logic        ir_we_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic        reg_we_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        instr_done_o,
  output logic        halted_o,
  output logic        err_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_HALT
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               err_q, err_nx;
  logic               pc_in_range;
  logic               func_ok;
  logic [2:0]         func_alu;
  logic               expire;

  assign pc_in_range = {1'b0, pc_i} < (33'(INSTR_NUM) << 2);
  assign expire      = !mem_ready_i && (cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign err_o       = err_q;

  always_comb begin
    func_ok  = 1'b1;
    func_alu = ALU_ADD;
    case (func_i)
      6'h20:   func_alu = ALU_ADD;
      6'h22:   func_alu = ALU_SUB;
      6'h24:   func_alu = ALU_AND;
      6'h25:   func_alu = ALU_OR;
      6'h2A:   func_alu = ALU_SLT;
      default: func_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nx     = state;
    err_nx       = err_q;
    mem_req_o    = 1'b0;
    mem_sel_o    = 1'b0;
    mem_we_o     = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = 1'b0;
    ir_we_o      = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = ALU_ADD;
    reg_we_o     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    halted_o     = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b_o = 2'd1;
        if (!pc_in_range) begin
          state_nx = S_HALT;
        end else begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_we_o  = 1'b1;
            pc_we_o  = 1'b1;
            state_nx = S_DECODE;
          end else if (expire) begin
            state_nx = S_HALT;
            err_nx   = 1'b1;
          end
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'd3;
        case (op_i)
          OP_RTYPE:        state_nx = S_EXEC_R;
          OP_ADDI, OP_SLTI: state_nx = S_EXEC_I;
          OP_LW, OP_SW:    state_nx = S_MEM_ADDR;
          OP_BEQ:          state_nx = S_BRANCH;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_nx = S_HALT;
            err_nx   = 1'b1;
`else
            state_nx = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = func_alu;
        if (func_ok) begin
          state_nx = S_WB_R;
        end else begin
`ifdef MC_ILLEGAL_TRAP_EN
          state_nx = S_HALT;
          err_nx   = 1'b1;
`else
          state_nx = S_FETCH;
`endif
        end
      end
      S_WB_R: begin
        reg_we_o  = (rd_i != 5'd0);
        reg_dst_o = 1'b1;
        state_nx  = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        alu_op_o    = (op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_nx    = S_WB_I;
      end
      S_WB_I: begin
        reg_we_o = (rt_i != 5'd0);
        state_nx = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'd2;
        if (!addr_ok_i)         state_nx = S_FETCH;
        else if (op_i == OP_LW) state_nx = S_MEM_RD;
        else                    state_nx = S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        mem_sel_o = 1'b1;
        if (mem_ready_i) begin
          state_nx = S_WB_MEM;
        end else if (expire) begin
          state_nx = S_HALT;
          err_nx   = 1'b1;
        end
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_sel_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_ready_i) begin
          state_nx = S_FETCH;
        end else if (expire) begin
          state_nx = S_HALT;
          err_nx   = 1'b1;
        end
      end
      S_WB_MEM: begin
        reg_we_o     = (rt_i != 5'd0);
        mem_to_reg_o = 1'b1;
        state_nx     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_SUB;
        pc_src_o    = 1'b1;
        pc_we_o     = zero_i;
        state_nx    = S_FETCH;
      end
      S_HALT:  halted_o = 1'b1;
      default: state_nx = S_FETCH;
    endcase
  end

  // Retire = leaving an instruction's last state back to FETCH; waiting in FETCH is not a retire.
  assign instr_done_o = (state_nx == S_FETCH) && (state != S_FETCH) && (state != S_HALT);

  // The wait counter only runs while a request is outstanding in the same state.
  assign cnt_nx = (state_nx != state || mem_ready_i || !mem_req_o) ? '0 : cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_FETCH;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomised instruction-level bench for mc_control_unit against a per-instruction latency/strobe model.
// Honours MC_ILLEGAL_TRAP_EN for the illegal-instruction expectations.
module tb_mc_control_unit;

  localparam int unsigned INSTR_NUM = 256;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [5:0]  op_i = '0, func_i = '0;
  logic [4:0]  rt_i = '0, rd_i = '0;
  logic [31:0] pc_i = '0;
  logic        zero_i = 1'b0, addr_ok_i = 1'b1, mem_ready_i = 1'b0;
  logic        mem_req_o, mem_sel_o, mem_we_o, pc_we_o, pc_src_o, ir_we_o, alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [2:0]  alu_op_o;
  logic        reg_we_o, reg_dst_o, mem_to_reg_o, instr_done_o, halted_o, err_o;

  int vectors = 0;
  int miscompares = 0;

  mc_control_unit #(.MEM_TIMEOUT(16), .INSTR_NUM(INSTR_NUM)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .func_i(func_i), .rt_i(rt_i), .rd_i(rd_i),
    .pc_i(pc_i), .zero_i(zero_i), .addr_ok_i(addr_ok_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .mem_sel_o(mem_sel_o), .mem_we_o(mem_we_o), .pc_we_o(pc_we_o),
    .pc_src_o(pc_src_o), .ir_we_o(ir_we_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .reg_we_o(reg_we_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
    .instr_done_o(instr_done_o), .halted_o(halted_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int lat; int regw; int dst; int m2r; int memw; int req; int pcw;
    int exop; int exa; int exb; int exsrc;
  } exp_t;

  logic [5:0] funcs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [5:0] ops   [7] = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04};

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Instruction-level expectations: cycle count and how many cycles each strobe is seen.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic z, input logic aok,
                                 input int fw, input int dw);
    exp_t m;
    int idx;
    m = '{default: 0};
    m.req = fw + 1;
    m.pcw = 1;
    case (op)
      6'h00: begin
        m.exa = 1;
        idx = -1;
        for (int i = 0; i < 5; i++) if (funcs[i] == fn) idx = i;
        if (idx >= 0) begin
          m.lat = 4; m.regw = int'(rd != 0); m.dst = 1; m.exop = idx;
        end else m.lat = 3;
      end
      6'h08, 6'h0A: begin
        m.lat = 4; m.exa = 1; m.exb = 2; m.exop = (op == 6'h0A) ? 4 : 0; m.regw = int'(rt != 0);
      end
      6'h23: begin
        m.exa = 1; m.exb = 2;
        if (aok) begin m.lat = 5 + dw; m.regw = int'(rt != 0); m.m2r = 1; m.req += dw + 1; end
        else m.lat = 3;
      end
      6'h2B: begin
        m.exa = 1; m.exb = 2;
        if (aok) begin m.lat = 4 + dw; m.memw = dw + 1; m.req += dw + 1; end
        else m.lat = 3;
      end
      6'h04: begin
        m.lat = 3; m.exa = 1; m.exop = 1; m.exsrc = 1; m.pcw += int'(z);
      end
      default: m.lat = 2;
    endcase
    m.lat += fw;
    return m;
  endfunction

  // Entered #1 after a rising edge with the DUT in FETCH; leaves the same way.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                           input logic [4:0] rd, input logic z, input logic aok,
                           input int fw, input int dw);
    exp_t e;
    int cyc, wcnt, tgt;
    int n_req, n_regw, n_m2r, n_memw, n_pcw, n_irw, dst_seen;
    int dec_a, dec_b, dec_op, ex_a, ex_b, ex_op, ex_src;
    bit done;
    e = model(op, fn, rt, rd, z, aok, fw, dw);
    op_i = op; func_i = fn; rt_i = rt; rd_i = rd; zero_i = z; addr_ok_i = aok;
    cyc = 0; wcnt = 0; done = 0;
    n_req = 0; n_regw = 0; n_m2r = 0; n_memw = 0; n_pcw = 0; n_irw = 0; dst_seen = -1;
    dec_a = -1; dec_b = -1; dec_op = -1; ex_a = -1; ex_b = -1; ex_op = -1; ex_src = -1;
    while (!done && cyc < 64) begin
      if (mem_req_o) begin
        tgt = mem_sel_o ? dw : fw;
        mem_ready_i = (wcnt == tgt);
        wcnt = mem_ready_i ? 0 : wcnt + 1;
      end else mem_ready_i = 1'b0;
      #1;
      n_req += int'(mem_req_o); n_regw += int'(reg_we_o); n_m2r += int'(mem_to_reg_o);
      n_memw += int'(mem_we_o); n_pcw += int'(pc_we_o); n_irw += int'(ir_we_o);
      if (reg_we_o) dst_seen = int'(reg_dst_o);
      if (cyc == fw + 1) begin dec_a = int'(alu_src_a_o); dec_b = int'(alu_src_b_o); dec_op = int'(alu_op_o); end
      if (cyc == fw + 2) begin
        ex_a = int'(alu_src_a_o); ex_b = int'(alu_src_b_o); ex_op = int'(alu_op_o); ex_src = int'(pc_src_o);
      end
      done = instr_done_o;
      cyc++;
      @(posedge clk_i); #1;
    end
    mem_ready_i = 1'b0;
    check("done_seen", int'(done), 1);
    check("latency", cyc, e.lat);
    check("req_cycles", n_req, e.req);
    check("reg_we_cycles", n_regw, e.regw);
    check("mem_to_reg_cycles", n_m2r, e.m2r);
    check("mem_we_cycles", n_memw, e.memw);
    check("pc_we_cycles", n_pcw, e.pcw);
    check("ir_we_cycles", n_irw, 1);
    check("decode_src_b", dec_b, 3);
    check("decode_src_a_op", dec_a * 8 + dec_op, 0);
    if (e.regw != 0) check("reg_dst", dst_seen, e.dst);
    if (e.lat > fw + 2) begin
      check("exec_alu_op", ex_op, e.exop);
      check("exec_src_a", ex_a, e.exa);
      check("exec_src_b", ex_b, e.exb);
      check("exec_pc_src", ex_src, e.exsrc);
    end
    check("err_clear", int'(err_o), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    int n;
    logic [5:0] op, fn;
    // Reset: FETCH decode with pc in range
    pc_i = 32'h0;
    @(posedge clk_i); #1;
    check("rst_mem_req", int'(mem_req_o), 1);
    check("rst_src_b", int'(alu_src_b_o), 1);
    check("rst_quiet", int'({mem_sel_o, mem_we_o, pc_we_o, pc_src_o, ir_we_o, alu_src_a_o,
                             alu_op_o, reg_we_o, reg_dst_o, mem_to_reg_o, instr_done_o,
                             halted_o, err_o}), 0);
    rst_i = 1'b0;

    // Directed cases from the test plan
    pc_i = 32'h40;
    run_instr(6'h00, 6'h20, 5'd2, 5'd3, 1'b0, 1'b1, 0, 0);   // ADD $3,$1,$2
    run_instr(6'h08, 6'h05, 5'd0, 5'd0, 1'b0, 1'b1, 0, 0);   // ADDI $0,$1,5
    run_instr(6'h23, 6'h00, 5'd4, 5'd0, 1'b0, 1'b1, 0, 3);   // LW, 3 wait cycles
    run_instr(6'h04, 6'h00, 5'd1, 5'd0, 1'b1, 1'b1, 0, 0);   // BEQ taken
    run_instr(6'h04, 6'h00, 5'd1, 5'd0, 1'b0, 1'b1, 0, 0);   // BEQ not taken
    run_instr(6'h2B, 6'h00, 5'd1, 5'd0, 1'b0, 1'b0, 0, 0);   // SW misaligned
    run_instr(6'h2B, 6'h00, 5'd1, 5'd0, 1'b0, 1'b1, 2, 14);  // SW just inside timeout
    run_instr(6'h0A, 6'h00, 5'd7, 5'd0, 1'b0, 1'b1, 15, 0);  // SLTI, fetch waits 15

    // Randomised legal instruction stream
    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 6)];
      fn = (op == 6'h00) ? funcs[$urandom_range(0, 4)] : 6'($urandom);
      pc_i = 32'($urandom_range(0, INSTR_NUM - 1)) << 2;
      run_instr(op, fn, 5'($urandom), 5'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // Fetch timeout: request held 16 cycles, then HALT with err_o
    mem_ready_i = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (halted_o) break;
      n += int'(mem_req_o);
      @(posedge clk_i); #1;
    end
    check("timeout_req_cycles", n, 16);
    check("timeout_halted", int'(halted_o), 1);
    check("timeout_err", int'(err_o), 1);
    check("timeout_req_dropped", int'(mem_req_o), 0);
    do_reset();
    check("post_rst_err", int'(err_o), 0);
    check("post_rst_halted", int'(halted_o), 0);
    check("post_rst_req", int'(mem_req_o), 1);

    // Unknown opcode / unknown func
`ifdef MC_ILLEGAL_TRAP_EN
    op_i = 6'h3F; mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0; #1;
    check("trap_op_no_done", int'(instr_done_o), 0);
    @(posedge clk_i); #1;
    check("trap_op_halted", int'(halted_o), 1);
    check("trap_op_err", int'(err_o), 1);
    do_reset();
    op_i = 6'h00; func_i = 6'h3F; mem_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_ready_i = 1'b0;
    @(posedge clk_i); #1;
    check("trap_fn_no_done", int'(instr_done_o), 0);
    @(posedge clk_i); #1;
    check("trap_fn_halted", int'(halted_o), 1);
    check("trap_fn_err", int'(err_o), 1);
    do_reset();
`else
    run_instr(6'h3F, 6'h00, 5'd1, 5'd1, 1'b0, 1'b1, 0, 0);
    run_instr(6'h00, 6'h3F, 5'd1, 5'd1, 1'b0, 1'b1, 1, 0);
`endif

    // PC past instruction memory: no request, straight to HALT
    pc_i = 32'(INSTR_NUM) << 2;
    #1;
    check("pc_bound_no_req", int'(mem_req_o), 0);
    @(posedge clk_i); #1;
    check("pc_bound_halted", int'(halted_o), 1);
    check("pc_bound_err", int'(err_o), 0);
    pc_i = 32'h0;
    do_reset();
    check("final_fetch_req", int'(mem_req_o), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multi-cycle control FSM for the MIPS datapath: ADD, SUB, AND, OR, SLT, ADDI, LW, SW, SLTI, BEQ.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives the PC, IR, ALU, register-file and memory-request controls.
- Arbitrates the single shared memory port between instruction fetch and data access, using a req/ready handshake with timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready_i before abort
INSTR_NUM, 256, instruction-memory depth in words, used for the halt bound

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, synchronous, active-high
op_i  input  6  IR[31:26]
func_i  input  6  IR[5:0]
rt_i  input  5  IR[20:16]
rd_i  input  5  IR[15:11]
pc_i  input  32  current PC byte address
zero_i  input  1  ALU zero flag
addr_ok_i  input  1  ALU result word-aligned and word index < DATA_NUM
mem_ready_i  input  1  shared memory access complete this cycle
mem_req_o  output  1  memory request
mem_sel_o  output  1  0=instruction port, 1=data port
mem_we_o  output  1  data write strobe
pc_we_o  output  1  PC load enable
pc_src_o  output  1  0=ALU result (PC+4), 1=ALUOut (branch target)
ir_we_o  output  1  IR load enable
alu_src_a_o  output  1  0=PC, 1=rs
alu_src_b_o  output  2  0=rt, 1=const 4, 2=sext imm, 3=sext imm<<2
alu_op_o  output  3  0=ADD 1=SUB 2=AND 3=OR 4=SLT
reg_we_o  output  1  register-file write enable
reg_dst_o  output  1  0=rt, 1=rd
mem_to_reg_o  output  1  writeback source, 1=MDR
instr_done_o  output  1  one-cycle pulse at instruction retire
halted_o  output  1  FSM in HALT
err_o  output  1  sticky, set on memory timeout

Behaviour:
- Reset (rst_i=1 at posedge): state=FETCH, timeout counter=0, err_o=0. All outputs 0 except mem_req_o=1, alu_src_b_o=1. The reset value of every output is the FETCH-state Moore decode.
- Outputs: Moore, decoded from state only, except pc_we_o in BRANCH (=zero_i) and reg_we_o gating.
- States and transitions:
  - FETCH: mem_req=1, sel=0, alu_src_a=PC, src_b=4, ADD. If pc_i/4 >= INSTR_NUM go to HALT, no request asserted. On mem_ready_i: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
  - DECODE: alu_src_a=PC, src_b=3, ADD (branch target into ALUOut).
    - op 0 -> EXEC_R
    - 08/0A -> EXEC_I
    - 23/2B -> MEM_ADDR
    - 04 -> BRANCH
    - other -> FETCH with instr_done.
  - EXEC_R: src_a=rs, src_b=rt, alu_op from func (20/22/24/25/2A). Unknown func -> FETCH, no write. Otherwise -> WB_R.
  - WB_R: reg_we = (rd_i!=0), reg_dst=1, then FETCH.
  - EXEC_I: src_a=rs, src_b=2, ADD for ADDI, SLT for SLTI, then WB_I.
  - WB_I: reg_we = (rt_i!=0), reg_dst=0, then FETCH.
  - MEM_ADDR: src_a=rs, src_b=2, ADD. If !addr_ok_i -> FETCH, access silently skipped. Else LW -> MEM_RD; SW -> MEM_WR.
  - MEM_RD: req=1, sel=1. On ready -> WB_MEM.
  - MEM_WR: req=1, sel=1, we=1. On ready -> FETCH.
  - WB_MEM: reg_we = (rt_i!=0), mem_to_reg=1, then FETCH.
  - BRANCH: src_a=rs, src_b=rt, SUB, pc_src=1, pc_we=zero_i, then FETCH.
  - HALT: absorbing until reset; all strobes 0, halted_o=1.
- instr_done_o pulses in the final cycle of each instruction (the cycle whose next state is FETCH).
- Latency with zero-wait memory:
  - R/ADDI/SLTI: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
  - Each memory wait cycle adds 1.
- Handshake: mem_req_o and the controls held stable until the mem_ready_i cycle. Counter clears on ready or on a state change.
- Timeout: counter reaches MEM_TIMEOUT without ready -> request dropped, err_o=1, HALT. No PC/IR/register/memory update.
- Reset mid-access: request drops next cycle, FSM returns to FETCH. No partial writeback.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE, or an unknown func in EXEC_R, goes to HALT with err_o=1; instr_done_o is not pulsed.
- Undefined: unknown instructions retire as NOP (return to FETCH, instr_done_o pulse, err_o stays 0).

Test Plan:
- ADD $3,$1,$2 with ready tied 1 -> states FETCH,DECODE,EXEC_R,WB_R; reg_we_o=1, reg_dst_o=1 in cycle 4; instr_done_o pulse in cycle 4.
- ADDI $0,$1,5 -> reg_we_o stays 0 throughout; 4 cycles.
- LW with mem_ready_i delayed 3 cycles in MEM_RD -> mem_req_o/mem_sel_o=1 held for 4 cycles; mem_to_reg_o=1 in WB_MEM; 8 cycles total.
- BEQ: zero_i=1 -> pc_we_o=1, pc_src_o=1 in BRANCH. zero_i=0 -> pc_we_o=0. 3 cycles each.
- SW with addr_ok_i=0 -> MEM_ADDR goes to FETCH; mem_we_o never asserted.
- mem_ready_i held 0 in FETCH -> after 16 cycles err_o=1, halted_o=1. Assert rst_i for 1 cycle -> FETCH, err_o=0. Opcode 0x3F with MC_ILLEGAL_TRAP_EN -> HALT; without it -> FETCH after 2 cycles.
